// File: rtl/leds_pwm_pkg.sv
// Shared widths, level limits and the saturating fade step for the LED PWM fader.
package leds_pwm_pkg;

  localparam int unsigned LED_W = 8;
  localparam int unsigned LVL_W = 8;

  localparam logic [LVL_W-1:0] LVL_MAX = 8'd255;
  localparam logic [LVL_W-1:0] LVL_MIN = 8'd0;

  typedef enum logic [1:0] {
    LVL_HOLD = 2'd0,
    LVL_JUMP = 2'd1,
    LVL_STEP = 2'd2
  } lvl_op_e;

  // Moves level one step toward target; the spare carry/borrow bit drives the clamp.
  function automatic logic [LVL_W-1:0] sat_step(
    input logic [LVL_W-1:0] level,
    input logic [LVL_W-1:0] target,
    input logic [LVL_W-1:0] step
  );
    logic [LVL_W:0] wide;
    wide     = '0;
    sat_step = level;
    if (level < target) begin
      wide     = {1'b0, level} + {1'b0, step};
      sat_step = wide[LVL_W] ? LVL_MAX : wide[LVL_W-1:0];
    end else if (level > target) begin
      wide     = {1'b0, level} - {1'b0, step};
      sat_step = wide[LVL_W] ? LVL_MIN : wide[LVL_W-1:0];
    end
  endfunction

endpackage

// File: rtl/leds_pwm_channel.sv
// One LED: brightness level register fading toward on/off, compared against the shared PWM count.
module leds_pwm_channel
  import leds_pwm_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req,
  input  logic             bypass,
  input  logic             tick,
  input  logic [LVL_W-1:0] pwm_cnt,
  output logic             led_bit,
  output logic             busy_bit
);

  localparam logic [LVL_W-1:0] STEP_L = LVL_W'(STEP);

  logic [LVL_W-1:0] level_q, level_d;
  logic [LVL_W-1:0] target;
  logic             led_q, led_d;
  lvl_op_e          op;

  always_comb begin
    target = req ? LVL_MAX : LVL_MIN;
    // Bypass wins over a coincident fade tick.
    op = LVL_HOLD;
    if (bypass) begin
      op = LVL_JUMP;
    end else if (tick) begin
      op = LVL_STEP;
    end
  end

  always_comb begin
    level_d = level_q;
    unique case (op)
      LVL_JUMP: level_d = target;
      LVL_STEP: level_d = sat_step(level_q, target, STEP_L);
      default:  level_d = level_q;
    endcase
    led_d = (level_q == LVL_MAX) | (pwm_cnt < level_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

  assign led_bit  = led_q;
  assign busy_bit = (level_q != target);

endmodule

// File: rtl/leds_pwm_fader.sv
// LED PIO pattern to PWM-faded LED pins: shared prescaler and PWM counter, one channel per LED.
module leds_pwm_fader
  import leds_pwm_pkg::*;
#(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned STEP     = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [LED_W-1:0] pattern,
  input  logic             bypass,
  output logic [LED_W-1:0] led,
  output logic             busy
);

  localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]  presc_q, presc_d;
  logic             tick;
  logic [LVL_W-1:0] pwm_q, pwm_d;
  logic [LED_W-1:0] pattern_q;
  logic [LED_W-1:0] busy_vec;

  always_comb begin
    tick    = (presc_q == PS_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
    pwm_d   = pwm_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q   <= '0;
      pwm_q     <= '0;
      pattern_q <= '0;
    end else begin
      presc_q   <= presc_d;
      pwm_q     <= pwm_d;
      pattern_q <= pattern;
    end
  end

  for (genvar i = 0; i < LED_W; i++) begin : g_ch
    leds_pwm_channel #(
      .STEP(STEP)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (pattern_q[i]),
      .bypass  (bypass),
      .tick    (tick),
      .pwm_cnt (pwm_q),
      .led_bit (led[i]),
      .busy_bit(busy_vec[i])
    );
  end

  assign busy = |busy_vec;

endmodule

// File: tb/tb_leds_pwm_fader.sv
// Self-checking bench for leds_pwm_fader: scenario tasks plus randomized run against a behavioural model.
module tb_leds_pwm_fader;

  localparam int PA = 4;
  localparam int SA = 64;

  logic       clk;
  logic       rst_n;
  logic [7:0] pat_a, pat_b, pat_c;
  logic       byp_a, byp_b, byp_c;
  logic [7:0] led_a, led_b, led_c;
  logic       busy_a, busy_b, busy_c;

  int n_cmp;
  int n_bad;

  leds_pwm_fader #(.PRESCALE(PA), .STEP(SA)) dut (
    .clk(clk), .reset_n(rst_n), .pattern(pat_a), .bypass(byp_a), .led(led_a), .busy(busy_a)
  );
  leds_pwm_fader #(.PRESCALE(1), .STEP(1)) dut_fast (
    .clk(clk), .reset_n(rst_n), .pattern(pat_b), .bypass(byp_b), .led(led_b), .busy(busy_b)
  );
  leds_pwm_fader #(.PRESCALE(300), .STEP(64)) dut_slow (
    .clk(clk), .reset_n(rst_n), .pattern(pat_c), .bypass(byp_c), .led(led_c), .busy(busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference for dut: time since reset gives prescaler and PWM phase directly.
  int         m_n;
  int         m_lv[8];
  logic [7:0] m_pq;
  logic [7:0] m_led;

  always @(posedge clk) begin : model
    int   lv_n;
    int   tgt;
    logic tk;
    if (!rst_n) begin
      m_n   <= 0;
      m_pq  <= '0;
      m_led <= '0;
      for (int i = 0; i < 8; i++) m_lv[i] <= 0;
    end else begin
      tk = ((m_n % PA) == PA - 1);
      for (int i = 0; i < 8; i++) begin
        m_led[i] <= (m_lv[i] == 255) || ((m_n % 256) < m_lv[i]);
        tgt  = m_pq[i] ? 255 : 0;
        lv_n = m_lv[i];
        if (byp_a) lv_n = tgt;
        else if (tk) begin
          if (lv_n < tgt)      lv_n = (lv_n + SA > 255) ? 255 : lv_n + SA;
          else if (lv_n > tgt) lv_n = (lv_n - SA < 0) ? 0 : lv_n - SA;
        end
        m_lv[i] <= lv_n;
      end
      m_pq <= pat_a;
      m_n  <= m_n + 1;
    end
  end

  function automatic logic model_busy();
    for (int i = 0; i < 8; i++)
      if (m_lv[i] != (m_pq[i] ? 255 : 0)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    pat_a = 8'hFF; byp_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (led_a !== 8'h00) begin n_bad++; $display("FAIL reset_led: got %h expected 00", led_a); end
      n_cmp++;
      if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy_a !== 1'b1) begin n_bad++; $display("FAIL reset_release_busy: got %b expected 1", busy_a); end
    n_cmp++;
    if (led_a !== 8'h00) begin n_bad++; $display("FAIL reset_release_led: got %h expected 00", led_a); end
  endtask

  task automatic test_ramp();
    pat_a = 8'h00; byp_a = 1'b0;
    do_reset(2);
    pat_a = 8'h01;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      n_cmp++;
      if (busy_a !== (k < 16)) begin n_bad++; $display("FAIL ramp_busy@%0d: got %b expected %b", k, busy_a, (k < 16)); end
      n_cmp++;
      if (led_a !== m_led) begin n_bad++; $display("FAIL ramp_led@%0d: got %h expected %h", k, led_a, m_led); end
      n_cmp++;
      if (led_a[7:1] !== 7'd0) begin n_bad++; $display("FAIL ramp_others@%0d: got %h expected 00", k, led_a[7:1]); end
    end
  endtask

  task automatic test_duty();
    int hi;
    pat_c = 8'h00; byp_c = 1'b0;
    do_reset(2);
    pat_c = 8'h01;
    repeat (330) @(negedge clk);
    hi = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (led_c[0]) hi++;
      if (k % 64 == 0) begin
        n_cmp++;
        if (led_c[7:1] !== 7'd0) begin n_bad++; $display("FAIL duty_others: got %h expected 00", led_c[7:1]); end
      end
    end
    n_cmp++;
    if (hi != 64) begin n_bad++; $display("FAIL duty_64: got %0d expected 64", hi); end
  endtask

  task automatic test_reversal();
    pat_a = 8'h00; byp_a = 1'b0;
    do_reset(2);
    pat_a = 8'h01;
    repeat (8) @(negedge clk);
    pat_a = 8'h00;
    for (int k = 9; k <= 40; k++) begin
      @(negedge clk);
      n_cmp++;
      if (busy_a !== (k < 16)) begin n_bad++; $display("FAIL rev_busy@%0d: got %b expected %b", k, busy_a, (k < 16)); end
      n_cmp++;
      if (led_a !== m_led) begin n_bad++; $display("FAIL rev_led@%0d: got %h expected %h", k, led_a, m_led); end
      if (k >= 17) begin
        n_cmp++;
        if (led_a !== 8'h00) begin n_bad++; $display("FAIL rev_off@%0d: got %h expected 00", k, led_a); end
      end
    end
  endtask

  task automatic test_bypass_latency();
    logic [7:0] exp_led;
    pat_a = 8'h00; byp_a = 1'b1;
    do_reset(2);
    repeat (5) @(negedge clk);
    pat_a = 8'hA5;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_led = (k >= 3) ? 8'hA5 : 8'h00;
      n_cmp++;
      if (led_a !== exp_led) begin n_bad++; $display("FAIL byp_led@%0d: got %h expected %h", k, led_a, exp_led); end
      n_cmp++;
      if (busy_a !== (k == 1)) begin n_bad++; $display("FAIL byp_busy@%0d: got %b expected %b", k, busy_a, (k == 1)); end
    end
  endtask

  task automatic test_bypass_tick();
    int lows;
    pat_b = 8'h00; byp_b = 1'b0;
    do_reset(2);
    pat_b = 8'h01;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      if (k >= 255) begin
        n_cmp++;
        if (busy_b !== (k == 255)) begin n_bad++; $display("FAIL fast_fade_busy@%0d: got %b expected %b", k, busy_b, (k == 255)); end
      end
    end
    pat_b = 8'h00; byp_b = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy_b !== 1'b0) begin n_bad++; $display("FAIL jump_down_busy: got %b expected 0", busy_b); end
    @(negedge clk);
    n_cmp++;
    if (led_b !== 8'h00) begin n_bad++; $display("FAIL jump_down_led: got %h expected 00", led_b); end
    pat_b = 8'h01;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy_b !== 1'b0) begin n_bad++; $display("FAIL jump_up_busy: got %b expected 0", busy_b); end
    lows = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (led_b[0] !== 1'b1) lows++;
    end
    n_cmp++;
    if (lows != 0) begin n_bad++; $display("FAIL jump_up_full: got %0d low cycles expected 0", lows); end
    byp_b = 1'b0;
  endtask

  task automatic test_reset_mid_fade();
    pat_a = 8'h00; byp_a = 1'b0;
    do_reset(2);
    pat_a = 8'h08;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (led_a !== 8'h00) begin n_bad++; $display("FAIL midreset_led: got %h expected 00", led_a); end
    n_cmp++;
    if (busy_a !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b expected 0", busy_a); end
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      n_cmp++;
      if (led_a !== m_led) begin n_bad++; $display("FAIL restart_led@%0d: got %h expected %h", k, led_a, m_led); end
      n_cmp++;
      if (busy_a !== model_busy()) begin n_bad++; $display("FAIL restart_busy@%0d: got %b expected %b", k, busy_a, model_busy()); end
    end
  endtask

  task automatic test_random();
    pat_a = 8'h00; byp_a = 1'b0;
    do_reset(2);
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 19) == 0) pat_a = 8'($urandom);
      if ($urandom_range(0, 39) == 0) byp_a = ~byp_a;
      @(negedge clk);
      n_cmp++;
      if (led_a !== m_led) begin n_bad++; $display("FAIL rand_led@%0d: got %h expected %h", k, led_a, m_led); end
      n_cmp++;
      if (busy_a !== model_busy()) begin n_bad++; $display("FAIL rand_busy@%0d: got %b expected %b", k, busy_a, model_busy()); end
    end
    byp_a = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0;
    pat_a = '0; pat_b = '0; pat_c = '0;
    byp_a = 1'b0; byp_b = 1'b0; byp_c = 1'b0;
    test_reset();
    test_ramp();
    test_duty();
    test_reversal();
    test_bypass_latency();
    test_bypass_tick();
    test_reset_mid_fade();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
